// File: rtl/vacc_readout.sv
// Read-side companion of the vector accumulator: captures dumped spectra, requantizes each
// bin by shift-and-saturate, ping-pongs two banks and streams completed frames over AXI4-Stream.
module vacc_readout #(
  parameter int VECTOR_WIDTH = 11,
  parameter int INPUT_WIDTH  = 128,
  parameter int OUTPUT_WIDTH = 32,
  parameter int SHIFT        = 0,
  parameter int SEQ_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [INPUT_WIDTH-1:0]  wr_data,
  input  logic [VECTOR_WIDTH-1:0] wr_addr,
  input  logic                    wr_en,
  output logic [OUTPUT_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [SEQ_WIDTH-1:0]    m_tuser,
  output logic [15:0]             dropped_frames
);

  localparam int DEPTH = 1 << VECTOR_WIDTH;
  localparam logic [VECTOR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [INPUT_WIDTH-1:0]  MAX_OUT   = INPUT_WIDTH'({OUTPUT_WIDTH{1'b1}});

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic       {R_IDLE, R_STREAM}       r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  // Stage 1: requantized write
  logic                    s1_valid;
  logic [VECTOR_WIDTH-1:0] s1_addr;
  logic [OUTPUT_WIDTH-1:0] s1_data;

  // Bank bookkeeping
  logic                            wbank, rbank;
  logic [1:0]                      bank_full;
  logic [1:0][SEQ_WIDTH-1:0]       bank_seq;
  logic [SEQ_WIDTH-1:0]            seq, cur_seq;

  // Read pipeline: RAM output register plus a 2-entry skid (m_* is the head)
  logic [VECTOR_WIDTH-1:0] raddr;
  logic                    issue_done;
  logic                    rd_valid, rd_last;
  logic [OUTPUT_WIDTH-1:0] rd_data;
  logic                    sk_valid, sk_last;
  logic [OUTPUT_WIDTH-1:0] sk_data;

  logic [INPUT_WIDTH-1:0]  shifted;
  logic [OUTPUT_WIDTH-1:0] sat_data;
  logic                    s1_first, s1_last, bank_free;
  logic                    ram_we, ram_re, pop;
  logic [1:0]              occ;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    shifted   = wr_data >> SHIFT;
    sat_data  = (shifted > MAX_OUT) ? '1 : shifted[OUTPUT_WIDTH-1:0];
    s1_first  = (s1_addr == '0);
    s1_last   = (s1_addr == LAST_ADDR);
    // Banks fill and drain in the same order, so if wbank is occupied both are.
    bank_free = !bank_full[wbank];
    pop       = m_tvalid && m_tready;
    occ       = 2'(m_tvalid) + 2'(sk_valid) + 2'(rd_valid) - 2'(pop);

    ram_we = 1'b0;
    if (s1_valid) begin
      if (w_state == W_FILL) ram_we = 1'b1;
      else                   ram_we = s1_first && bank_free;
    end

    ram_re = 1'b0;
    if (r_state == R_IDLE)  ram_re = bank_full[rbank];
    else                    ram_re = !issue_done && (occ <= 2'd1);
  end

  // NOTE: the bin store has no reset so it maps to block RAM; bank_full and rd_valid carry validity.
  logic [OUTPUT_WIDTH-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) mem[{wbank, s1_addr}] <= s1_data;
    if (ram_re) rd_data <= mem[{rbank, raddr}];
  end

  // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_addr        <= '0;
      s1_data        <= '0;
      w_state        <= W_IDLE;
      r_state        <= R_IDLE;
      wbank          <= 1'b0;
      rbank          <= 1'b0;
      bank_full      <= '0;
      bank_seq       <= '0;
      seq            <= '0;
      cur_seq        <= '0;
      dropped_frames <= '0;
      raddr          <= '0;
      issue_done     <= 1'b0;
      rd_valid       <= 1'b0;
      rd_last        <= 1'b0;
      sk_valid       <= 1'b0;
      sk_last        <= 1'b0;
      sk_data        <= '0;
      m_tvalid       <= 1'b0;
      m_tlast        <= 1'b0;
      m_tdata        <= '0;
      m_tuser        <= '0;
    end else begin
      s1_valid <= ce && wr_en;
      s1_addr  <= wr_addr;
      s1_data  <= sat_data;

      case (w_state)
        W_IDLE: begin
          if (s1_valid && s1_first) begin
            seq     <= seq + SEQ_WIDTH'(1);
            cur_seq <= seq;
            if (bank_free) begin
              w_state <= W_FILL;
            end else begin
              w_state <= W_DROP;
              if (dropped_frames != 16'hFFFF) dropped_frames <= dropped_frames + 16'd1;
            end
          end
        end
        W_FILL: begin
          if (s1_valid && s1_last) begin
            bank_full[wbank] <= 1'b1;
            bank_seq[wbank]  <= cur_seq;
            wbank            <= ~wbank;
            w_state          <= W_IDLE;
          end
        end
        W_DROP: begin
          if (s1_valid) begin
            if (s1_last) begin
              w_state <= W_IDLE;
            end else if (s1_first && bank_free) begin
              seq     <= seq + SEQ_WIDTH'(1);
              cur_seq <= seq;
              w_state <= W_FILL;
            end
          end
        end
        default: w_state <= W_IDLE;
      endcase

      rd_valid <= ram_re;
      if (ram_re) begin
        rd_last <= (raddr == LAST_ADDR);
        raddr   <= raddr + VECTOR_WIDTH'(1);
        if (raddr == LAST_ADDR) issue_done <= 1'b1;
      end

      case (r_state)
        R_IDLE:   if (bank_full[rbank]) r_state <= R_STREAM;
        R_STREAM: begin
          if (pop && m_tlast) begin
            bank_full[rbank] <= 1'b0;
            rbank            <= ~rbank;
            issue_done       <= 1'b0;
            r_state          <= R_IDLE;
          end
        end
        default:  r_state <= R_IDLE;
      endcase

      // Head only changes when empty or handshaking, keeping the beat stable under stall.
      if (pop || !m_tvalid) begin
        if (sk_valid) begin
          m_tvalid <= 1'b1;
          m_tdata  <= sk_data;
          m_tlast  <= sk_last;
          m_tuser  <= bank_seq[rbank];
          sk_valid <= rd_valid;
          sk_data  <= rd_data;
          sk_last  <= rd_last;
        end else begin
          m_tvalid <= rd_valid;
          if (rd_valid) begin
            m_tdata <= rd_data;
            m_tlast <= rd_last;
            m_tuser <= bank_seq[rbank];
          end
        end
      end else if (rd_valid) begin
        sk_valid <= 1'b1;
        sk_data  <= rd_data;
        sk_last  <= rd_last;
      end
    end
  end

endmodule

// File: doc/vacc_readout.md
# vacc_readout

Read-side companion of the vector accumulator. It captures each accumulated spectrum the accumulator dumps over its `we`/`addr`/`data_out` write port and requantizes every bin to a narrower unsigned word by shift-and-saturate. It holds the spectrum in a two-bank ping-pong buffer and streams each completed frame to the packetizer over an AXI4-Stream master. When both banks are occupied it drops whole frames, never partial ones.

## Interface
- `VECTOR_WIDTH`, 11: bin address width; frame length is 2^VECTOR_WIDTH bins.
- `INPUT_WIDTH`, 128: width of the accumulated bin value.
- `OUTPUT_WIDTH`, 32: width of the streamed bin value.
- `SHIFT`, 0: right-shift applied before saturation, 0 ≤ SHIFT < INPUT_WIDTH.
- `SEQ_WIDTH`, 16: frame sequence number width.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  clock enable, write side only.
- `wr_data`  in  INPUT_WIDTH  accumulated bin value.
- `wr_addr`  in  VECTOR_WIDTH  bin index.
- `wr_en`  in  1  bin-write strobe, qualified by `ce`.
- `m_tdata`  out  OUTPUT_WIDTH  requantized bin.
- `m_tvalid`  out  1  AXI-S valid.
- `m_tready`  in  1  AXI-S ready.
- `m_tlast`  out  1  high on bin 2^VECTOR_WIDTH-1.
- `m_tuser`  out  SEQ_WIDTH  sequence number of the frame, constant across all beats of the frame.
- `dropped_frames`  out  16  count of dropped frames; saturates at 0xFFFF.

## Operation
- Write capture:
  - A write is `ce && wr_en` sampled on the rising edge of `clk`.
  - Stage 1 registers `q = wr_data >> SHIFT`, forced to all-ones if `q ≥ 2^OUTPUT_WIDTH`, together with `wr_addr`.
  - Stage 2 writes that value into the RAM bank selected by `wbank`.
- Write FSM:
  - W_IDLE: a write at address 0 opens a frame and assigns `seq` to it, then `seq++` (wraps).
    - If a free bank exists → W_FILL.
    - If no bank is free → W_DROP and `dropped_frames++`.
    - Writes at any other address are ignored.
  - W_FILL: every write is stored at its address.
    - A write at address 0 restarts the frame in the same bank; no new seq is assigned.
    - A write at the last address marks the bank full, latches its seq, toggles `wbank` → W_IDLE.
  - W_DROP: writes are discarded.
    - A write at the last address → W_IDLE.
    - A write at address 0 with a free bank opens a new frame → W_FILL (seq assigned, no drop count).
- Read FSM:
  - R_IDLE: waits until bank `rbank` is full → R_STREAM.
  - R_STREAM: issues read addresses 0..2^VECTOR_WIDTH-1 into a 1-cycle-latency RAM, feeding a 2-entry skid/output register. The address advances only while the skid has room.
  - On acceptance of the `m_tlast` beat: bank `rbank` is freed, `rbank` toggles → R_IDLE.
- Both banks full and a write at address 0 arrives → the frame is dropped (W_DROP); no stored data is overwritten.
- A bank is never written and read simultaneously; RAM contents are not reset.
- The read side ignores `ce`.

## Timing
- Reset: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `m_tuser`=0, `dropped_frames`=0, `seq`=0, both banks empty, `wbank`=`rbank`=0, FSMs in W_IDLE/R_IDLE. Outputs clear immediately on `rst` assertion.
- Reset mid-frame or mid-stream: the partial frame and any unsent beats are discarded.
- Last-address write sampled at edge k:
  - RAM write and bank-full flag at edge k+1.
  - Read of address 0 issued at edge k+2.
  - `m_tvalid` high after edge k+3.
- With `m_tready`=1: one beat per cycle, 2^VECTOR_WIDTH contiguous beats.
- Back-to-back full banks: at most 2 idle cycles between a `m_tlast` handshake and the next frame's first beat.
- AXI-S rules:
  - While `m_tvalid && !m_tready`, `m_tdata`, `m_tlast`, `m_tuser` are stable.
  - `m_tvalid` never deasserts without a handshake, except on reset.
  - `m_tvalid` never depends combinationally on `m_tready`.
- `dropped_frames` updates the cycle after the dropping write.

## Test plan
- Ramp: VECTOR_WIDTH=3, SHIFT=4, write addr i with data (i<<4)|0xF for i=0..7, `m_tready`=1 → 8 beats, `m_tdata`=0..7, `m_tlast` only on beat 7, `m_tuser`=0, first `m_tvalid` 3 edges after the addr-7 write.
- Saturation: SHIFT=4, OUTPUT_WIDTH=32, data 2^36 → 0xFFFFFFFF; data 2^36-1 → 0xFFFFFFFF; data 2^35 → 0x80000000; data 0 → 0.
- Backpressure: `m_tready` random at 50% over 2 frames → beat order and values exactly match the writes; `m_tdata`/`m_tlast`/`m_tuser` stable while stalled; `m_tuser` 0 then 1.
- Overflow: `m_tready`=0, write 3 full frames, then release → frames seq 0 and 1 streamed, `dropped_frames`=1; a 4th frame streams with `m_tuser`=3.
- Qualification: writes with `ce`=0 are ignored; writes at addr 5 in W_IDLE are ignored; an addr-0 write mid-frame restarts the frame → a single frame is streamed, carrying the post-restart data.
- Async reset: assert `rst` at beat 3 of a stream, off-edge → `m_tvalid`=0 before the next edge; after release a new frame streams with `m_tuser`=0 and `dropped_frames`=0.
